apb_xfer_scheduler: RTL

Sequences the shared APB master port of the AXI-to-APB bridge. It arbitrates between the read path and the write path of the bridge using round-robin. It decodes the granted address to one of NUM_SLAVES PSEL lines and runs the APB SETUP/ACCESS protocol. Each transfer ends with a done/err response, including error completion for decode misses and for slaves that stall past a timeout.

---
 rtl/apb_xfer_scheduler_if.sv | 47 ++++
 rtl/apb_xfer_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/apb_xfer_scheduler_if.sv
// Bundle of the requester-side (read/write paths) and APB-side signals of the
// transfer scheduler. "master" is the scheduler's view, "slave" is the
// environment (requesters plus APB slaves).
interface apb_xfer_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             rd_req;
  logic [ADDR_WIDTH-1:0]            rd_addr;
  logic                             rd_gnt;
  logic                             rd_done;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_err;

  logic                             wr_req;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic [DATA_WIDTH/8-1:0]          wr_strb;
  logic                             wr_gnt;
  logic                             wr_done;
  logic                             wr_err;

  logic [ADDR_WIDTH-1:0]            paddr;
  logic [NUM_SLAVES-1:0]            psel;
  logic                             penable;
  logic                             pwrite;
  logic [DATA_WIDTH-1:0]            pwdata;
  logic [DATA_WIDTH/8-1:0]          pstrb;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES-1:0]            pslverr;

  modport master (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
           prdata, pready, pslverr,
    output rd_gnt, rd_done, rd_data, rd_err, wr_gnt, wr_done, wr_err,
           paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
           prdata, pready, pslverr,
    input  rd_gnt, rd_done, rd_data, rd_err, wr_gnt, wr_done, wr_err,
           paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_xfer_scheduler.sv
// Shared APB master port for the AXI-to-APB bridge: round-robin arbitration
// between read and write paths, address decode to one PSEL line, APB
// SETUP/ACCESS sequencing, and done/err completion including decode misses
// and slave timeouts.
module apb_xfer_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  apb_xfer_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef enum logic {WIN_RD, WIN_WR} winner_t;

  state_t                state;
  winner_t               last_winner;
  logic [IDX_W-1:0]      sel;
  logic [7:0]            tcnt;

  logic                  pick_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [IDX_W-1:0]      req_idx;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  req_hit;

  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ready;
  logic                  sel_err;
  logic                  xfer_end;

  // Round-robin pick and decode of the candidate request seen in IDLE
  always_comb begin
    pick_wr  = bus.wr_req & (~bus.rd_req | (last_winner == WIN_RD));
    req_addr = pick_wr ? bus.wr_addr : bus.rd_addr;
    req_idx  = req_addr[SLAVE_ADDR_BITS +: IDX_W];
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
    end
    // An index beyond NUM_SLAVES yields an all-zero one-hot, i.e. a miss.
    req_hit = (|req_onehot) &&
              ((req_addr >> (SLAVE_ADDR_BITS + IDX_W)) == '0);
  end

  // Response mux of the currently selected slave
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_rdata = bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = bus.pready[i];
        sel_err   = bus.pslverr[i];
      end
    end
    xfer_end = sel_ready || (tcnt == 8'(TIMEOUT_CYCLES - 1));
  end

  // Transfer FSM with registered APB and requester outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= WIN_WR;
      sel         <= '0;
      tcnt        <= '0;
      bus.rd_gnt  <= 1'b0;
      bus.rd_done <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_err  <= 1'b0;
      bus.wr_gnt  <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.wr_err  <= 1'b0;
      bus.paddr   <= '0;
      bus.psel    <= '0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.pwdata  <= '0;
      bus.pstrb   <= '0;
    end else begin
      bus.rd_gnt  <= 1'b0;
      bus.wr_gnt  <= 1'b0;
      bus.rd_done <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.rd_err  <= 1'b0;
      bus.wr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_req || bus.wr_req) begin
            last_winner <= pick_wr ? WIN_WR : WIN_RD;
            bus.rd_gnt  <= ~pick_wr;
            bus.wr_gnt  <= pick_wr;
            bus.paddr   <= req_addr;
            bus.pwrite  <= pick_wr;
            bus.pwdata  <= pick_wr ? bus.wr_data : '0;
            bus.pstrb   <= pick_wr ? bus.wr_strb : '0;
            sel         <= req_idx;
            if (req_hit) begin
              state    <= SETUP;
              bus.psel <= req_onehot;
            end else begin
              // Decode miss completes in the grant cycle with no APB activity.
              state <= RESP;
              if (pick_wr) begin
                bus.wr_done <= 1'b1;
                bus.wr_err  <= 1'b1;
              end else begin
                bus.rd_done <= 1'b1;
                bus.rd_err  <= 1'b1;
                bus.rd_data <= '0;
              end
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end
        ACCESS: begin
          if (xfer_end) begin
            state       <= RESP;
            bus.psel    <= '0;
            bus.penable <= 1'b0;
            // last_winner already names the owner of the in-flight transfer.
            if (last_winner == WIN_WR) begin
              bus.wr_done <= 1'b1;
              bus.wr_err  <= sel_ready ? sel_err : 1'b1;
            end else begin
              bus.rd_done <= 1'b1;
              bus.rd_err  <= sel_ready ? sel_err : 1'b1;
              bus.rd_data <= sel_ready ? sel_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          tcnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
